// File: rtl/look_ahead_carry.sv
// Carry-lookahead generator: flat sum-of-products carries from per-bit P/G and Cin,
// plus a one-cycle registered copy with group propagate/generate for cascading.
module look_ahead_carry #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_q,
    output logic             PG_q,
    output logic             GG_q,
    output logic             out_valid
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
        $error("look_ahead_carry: WIDTH must be in 1..32");
    end

    // Product of P[lo..hi]; an empty range (lo > hi) is the identity 1.
    function automatic logic span_and(input logic [WIDTH-1:0] p, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (k >= lo && k <= hi) begin
                r = r & p[k];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] carry;
    logic             group_p;
    logic             group_g;

    // Each carry is an independent OR of product terms, so no carry feeds another.
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = span_and(P, 0, i) & Cin;
            for (int j = 0; j <= i; j++) begin
                carry[i] = carry[i] | (G[j] & span_and(P, j + 1, i));
            end
        end
    end

    always_comb begin
        group_p = &P;
        group_g = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            group_g = group_g | (G[j] & span_and(P, j + 1, WIDTH - 1));
        end
    end

    assign C = carry;

    // Result registers hold between captures; out_valid is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C_q       <= '0;
            PG_q      <= 1'b0;
            GG_q      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                C_q  <= carry;
                PG_q <= group_p;
                GG_q <= group_g;
            end
        end
    end

endmodule

// File: tb/tb_look_ahead_carry.sv
// Bench for look_ahead_carry: directed vectors, a registered-result scoreboard,
// async reset behaviour and an exhaustive sweep against a recursive carry model.
module tb_look_ahead_carry;

    localparam int WIDTH = 4;
    localparam int EW    = WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] G;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] C_q;
    logic             PG_q;
    logic             GG_q;
    logic             out_valid;

    logic [EW-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    look_ahead_carry #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .P(P),
        .G(G),
        .Cin(Cin),
        .in_valid(in_valid),
        .C(C),
        .C_q(C_q),
        .PG_q(PG_q),
        .GG_q(GG_q),
        .out_valid(out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ripple recursion, independent of the flat form in the RTL.
    function automatic logic [WIDTH-1:0] ref_c(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                                               input logic cin);
        logic [WIDTH-1:0] c;
        logic prev;
        prev = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = g[i] | (p[i] & prev);
            prev = c[i];
        end
        return c;
    endfunction

    function automatic logic ref_gg(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] c;
        c = ref_c(p, g, 1'b0);
        return c[WIDTH-1];
    endfunction

    // Driver: called at posedge+2; applies inputs, checks C, queues the registered result.
    task automatic issue(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g, input logic cin,
                         input logic v, input logic [WIDTH-1:0] exp_c, input logic exp_pg,
                         input logic exp_gg);
        P        = p;
        G        = g;
        Cin      = cin;
        in_valid = v;
        #1;
        check("comb_C", 32'(C), 32'(exp_c));
        if (v) exp_q.push_back({exp_c, exp_pg, exp_gg});
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("reg_result", 32'({C_q, PG_q, GG_q}), 32'(e));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ep;
        logic [WIDTH-1:0] eg;
        logic ec;
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        P        = '0;
        G        = '0;
        Cin      = 1'b0;
        in_valid = 1'b0;
        #12;
        check("reset_state", 32'({C_q, PG_q, GG_q, out_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // combinational vectors
        issue(4'b1101, 4'b1010, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b1);
        issue(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        issue(4'b0000, 4'b1111, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
        issue(4'b1010, 4'b0101, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);

        // full-propagate toggle
        issue(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        issue(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        issue(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);

        // single pulse, then hold with in_valid low
        issue(4'b1101, 4'b1010, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1);
        check("pulse_out_valid", 32'(out_valid), 32'd1);
        check("pulse_C_q", 32'(C_q), 32'hE);
        check("pulse_GG_q", 32'(GG_q), 32'd1);
        issue(4'b0011, 4'b0101, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0);
        check("hold_out_valid", 32'(out_valid), 32'd0);
        check("hold_C_q", 32'(C_q), 32'hE);
        check("hold_GG_q", 32'(GG_q), 32'd1);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("hold2_C_q", 32'(C_q), 32'hE);

        // streaming, back to back
        issue(4'b1101, 4'b1010, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1);
        issue(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
        check("stream_ov1", 32'(out_valid), 32'd1);
        issue(4'b0000, 4'b1111, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
        check("stream_ov2", 32'(out_valid), 32'd1);
        issue(4'b1010, 4'b0101, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        check("stream_ov3", 32'(out_valid), 32'd1);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        // async reset mid-cycle after a capture
        issue(4'b1101, 4'b1010, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_regs", 32'({C_q, PG_q, GG_q, out_valid}), 32'd0);
        P   = 4'b1111;
        G   = 4'b0000;
        Cin = 1'b1;
        #1;
        check("reset_C_tracks", 32'(C), 32'hF);
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        check("reset_wins_regs", 32'({C_q, PG_q, GG_q, out_valid}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("post_reset_ov", 32'(out_valid), 32'd0);

        // exhaustive sweep, streamed
        for (int k = 0; k < 512; k++) begin
            ep = k[3:0];
            eg = k[7:4];
            ec = k[8];
            issue(ep, eg, ec, 1'b1, ref_c(ep, eg, ec), &ep, ref_gg(ep, eg));
        end
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        issue(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
